// File: rtl/hdu_pkg.sv
// Shared types and constants for the multi-cycle hazard detection unit.
package hdu_pkg;

   localparam int unsigned HDU_REG_AW = 5;

   typedef enum logic [1:0] {
      HDU_RUN       = 2'd0,
      HDU_LOAD_WAIT = 2'd1,
      HDU_MDU_WAIT  = 2'd2
   } hdu_state_e;

endpackage

// File: rtl/hdu_dep_cmp.sv
// Load-use dependency comparator: EX load destination against ID sources, x0 filtered.
module hdu_dep_cmp
   import hdu_pkg::*;
#(
   parameter int unsigned REG_AW = HDU_REG_AW
) (
   input  logic              ex_rdwren_i,
   input  logic              ex_mem_rden_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   output logic              hazard_o
);

   logic rd_valid;
   logic rs1_hit;
   logic rs2_hit;

   assign rd_valid = ex_mem_rden_i & ex_rdwren_i & (ex_rd_i != '0);
   assign rs1_hit  = id_rs1_used_i & (id_rs1_i == ex_rd_i);
   assign rs2_hit  = id_rs2_used_i & (id_rs2_i == ex_rd_i);
   assign hazard_o = rd_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hdu_multicycle.sv
// Pipeline hazard/stall controller: multi-bubble load-use, MDU handshake,
// data-memory freeze and branch-flush priority.
module hdu_multicycle
   import hdu_pkg::*;
#(
   parameter int unsigned REG_AW   = HDU_REG_AW,
   parameter int unsigned LOAD_LAT = 1,
   parameter bit          MDU_EN   = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              br_flush_i,
   input  logic              dmem_ready_i,
   input  logic              IDEX_rdwren_i,
   input  logic              IDEX_mem_rden_i,
   input  logic              IDEX_mdu_i,
   input  logic [REG_AW-1:0] IDEX_rd_i,
   input  logic [REG_AW-1:0] IFID_rs1_i,
   input  logic [REG_AW-1:0] IFID_rs2_i,
   input  logic              IFID_rs1_used_i,
   input  logic              IFID_rs2_used_i,
   input  logic              mdu_done_i,
   output logic              IFID_clear_o,
   output logic              IDEX_clear_o,
   output logic              EXMEM_clear_o,
   output logic              pc_wren_o,
   output logic              IFID_wren_o,
   output logic              IDEX_wren_o,
   output logic              EXMEM_wren_o,
   output logic              MEMWB_wren_o,
   output logic              mdu_start_o,
   output logic              mdu_kill_o,
   output logic              stall_o
);

   localparam int unsigned CNT_W = $clog2(LOAD_LAT + 1);

   hdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_use;

   hdu_dep_cmp #(
      .REG_AW (REG_AW)
   ) u_dep_cmp (
      .ex_rdwren_i   (IDEX_rdwren_i),
      .ex_mem_rden_i (IDEX_mem_rden_i),
      .ex_rd_i       (IDEX_rd_i),
      .id_rs1_i      (IFID_rs1_i),
      .id_rs2_i      (IFID_rs2_i),
      .id_rs1_used_i (IFID_rs1_used_i),
      .id_rs2_used_i (IFID_rs2_used_i),
      .hazard_o      (load_use)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= HDU_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and pipeline-control decode, highest priority first.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      IFID_clear_o  = 1'b0;
      IDEX_clear_o  = 1'b0;
      EXMEM_clear_o = 1'b0;
      pc_wren_o     = 1'b1;
      IFID_wren_o   = 1'b1;
      IDEX_wren_o   = 1'b1;
      EXMEM_wren_o  = 1'b1;
      MEMWB_wren_o  = 1'b1;
      mdu_start_o   = 1'b0;
      mdu_kill_o    = 1'b0;

      if (!rst_ni) begin
         IFID_clear_o  = 1'b1;
         IDEX_clear_o  = 1'b1;
         EXMEM_clear_o = 1'b1;
         state_d       = HDU_RUN;
         cnt_d         = '0;
      end else if (!dmem_ready_i) begin
         pc_wren_o    = 1'b0;
         IFID_wren_o  = 1'b0;
         IDEX_wren_o  = 1'b0;
         EXMEM_wren_o = 1'b0;
         MEMWB_wren_o = 1'b0;
      end else if (br_flush_i) begin
         IFID_clear_o  = 1'b1;
         IDEX_clear_o  = 1'b1;
         EXMEM_clear_o = 1'b1;
         mdu_kill_o    = MDU_EN && (state_q == HDU_MDU_WAIT);
         state_d       = HDU_RUN;
         cnt_d         = '0;
      end else begin
         unique case (state_q)
            HDU_RUN: begin
               if (load_use) begin
                  pc_wren_o    = 1'b0;
                  IFID_wren_o  = 1'b0;
                  IDEX_clear_o = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_d = HDU_LOAD_WAIT;
                     cnt_d   = CNT_W'(LOAD_LAT - 1);
                  end
               end else if (MDU_EN && IDEX_mdu_i) begin
                  mdu_start_o   = 1'b1;
                  pc_wren_o     = 1'b0;
                  IFID_wren_o   = 1'b0;
                  IDEX_wren_o   = 1'b0;
                  EXMEM_clear_o = 1'b1;
                  state_d       = HDU_MDU_WAIT;
               end
            end
            HDU_LOAD_WAIT: begin
               pc_wren_o    = 1'b0;
               IFID_wren_o  = 1'b0;
               IDEX_clear_o = 1'b1;
               cnt_d        = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = HDU_RUN;
               end
            end
            HDU_MDU_WAIT: begin
               if (mdu_done_i) begin
                  state_d = HDU_RUN;
               end else begin
                  pc_wren_o     = 1'b0;
                  IFID_wren_o   = 1'b0;
                  IDEX_wren_o   = 1'b0;
                  EXMEM_clear_o = 1'b1;
               end
            end
            default: begin
               state_d = HDU_RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign stall_o = ~pc_wren_o;

endmodule

// File: tb/tb_hdu_multicycle.sv
// Directed bench: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus; outputs
// are checked as an 11-bit control vector against hand-derived constants.
module tb_hdu_multicycle;

   localparam int unsigned AW = 5;

   // {IFID_clr, IDEX_clr, EXMEM_clr, pc_we, IFID_we, IDEX_we, EXMEM_we, MEMWB_we, start, kill, stall}
   localparam logic [10:0] V_DEF   = 11'b000_11111_00_0;
   localparam logic [10:0] V_RST   = 11'b111_11111_00_0;
   localparam logic [10:0] V_LU    = 11'b010_00111_00_1;
   localparam logic [10:0] V_FRZ   = 11'b000_00000_00_1;
   localparam logic [10:0] V_FL    = 11'b111_11111_00_0;
   localparam logic [10:0] V_FLK   = 11'b111_11111_01_0;
   localparam logic [10:0] V_MSTRT = 11'b001_00011_10_1;
   localparam logic [10:0] V_MHOLD = 11'b001_00011_00_1;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic          br_flush, dmem_ready, rdwren, mem_rden, mdu, mdu_done;
   logic [AW-1:0] rd, rs1, rs2;
   logic          rs1_used, rs2_used;
   logic [10:0]   obs_a, obs_b;
   int            errors = 0;
   int            checks = 0;

   always #5 clk = ~clk;

   hdu_multicycle #(.REG_AW(AW), .LOAD_LAT(1), .MDU_EN(1'b1)) u_lat1 (
      .clk_i(clk), .rst_ni(rst_ni), .br_flush_i(br_flush), .dmem_ready_i(dmem_ready),
      .IDEX_rdwren_i(rdwren), .IDEX_mem_rden_i(mem_rden), .IDEX_mdu_i(mdu), .IDEX_rd_i(rd),
      .IFID_rs1_i(rs1), .IFID_rs2_i(rs2), .IFID_rs1_used_i(rs1_used), .IFID_rs2_used_i(rs2_used),
      .mdu_done_i(mdu_done),
      .IFID_clear_o(obs_a[10]), .IDEX_clear_o(obs_a[9]), .EXMEM_clear_o(obs_a[8]),
      .pc_wren_o(obs_a[7]), .IFID_wren_o(obs_a[6]), .IDEX_wren_o(obs_a[5]),
      .EXMEM_wren_o(obs_a[4]), .MEMWB_wren_o(obs_a[3]),
      .mdu_start_o(obs_a[2]), .mdu_kill_o(obs_a[1]), .stall_o(obs_a[0])
   );

   hdu_multicycle #(.REG_AW(AW), .LOAD_LAT(3), .MDU_EN(1'b1)) u_lat3 (
      .clk_i(clk), .rst_ni(rst_ni), .br_flush_i(br_flush), .dmem_ready_i(dmem_ready),
      .IDEX_rdwren_i(rdwren), .IDEX_mem_rden_i(mem_rden), .IDEX_mdu_i(mdu), .IDEX_rd_i(rd),
      .IFID_rs1_i(rs1), .IFID_rs2_i(rs2), .IFID_rs1_used_i(rs1_used), .IFID_rs2_used_i(rs2_used),
      .mdu_done_i(mdu_done),
      .IFID_clear_o(obs_b[10]), .IDEX_clear_o(obs_b[9]), .EXMEM_clear_o(obs_b[8]),
      .pc_wren_o(obs_b[7]), .IFID_wren_o(obs_b[6]), .IDEX_wren_o(obs_b[5]),
      .EXMEM_wren_o(obs_b[4]), .MEMWB_wren_o(obs_b[3]),
      .mdu_start_o(obs_b[2]), .mdu_kill_o(obs_b[1]), .stall_o(obs_b[0])
   );

   task automatic chk(input string tag, input logic [10:0] exp_a, input logic [10:0] exp_b);
      #2;
      checks++;
      assert (obs_a === exp_a) else begin
         errors++;
         $error("FAIL %s lat1: observed=%b expected=%b", tag, obs_a, exp_a);
      end
      checks++;
      assert (obs_b === exp_b) else begin
         errors++;
         $error("FAIL %s lat3: observed=%b expected=%b", tag, obs_b, exp_b);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      br_flush = 1'b0; dmem_ready = 1'b1; rdwren = 1'b0; mem_rden = 1'b0;
      mdu = 1'b0; mdu_done = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
      rs1_used = 1'b0; rs2_used = 1'b0;
   endtask

   // lw rd_v in EX, ID reads rs1_v/rs2_v
   task automatic load_dep(input logic [AW-1:0] rd_v, input logic [AW-1:0] rs1_v, input logic u1,
                           input logic [AW-1:0] rs2_v, input logic u2);
      idle();
      mem_rden = 1'b1; rdwren = 1'b1; rd = rd_v;
      rs1 = rs1_v; rs1_used = u1; rs2 = rs2_v; rs2_used = u2;
   endtask

   initial begin
      idle();
      rst_ni = 1'b0;
      #1;
      chk("reset", V_RST, V_RST);
      tick();
      rst_ni = 1'b1;
      chk("post_reset", V_DEF, V_DEF);
      tick();

      // lw x5 ; add x6,x5,x1
      load_dep(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
      chk("lu_hit", V_LU, V_LU);
      tick();
      idle();
      chk("lu_wait2", V_DEF, V_LU);
      tick();
      chk("lu_wait1", V_DEF, V_LU);
      tick();
      chk("lu_done", V_DEF, V_DEF);
      tick();

      load_dep(5'd5, 5'd5, 1'b0, 5'd1, 1'b1);
      chk("lu_rs1_unused", V_DEF, V_DEF);
      tick();
      load_dep(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      chk("lu_x0", V_DEF, V_DEF);
      tick();
      load_dep(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
      rdwren = 1'b0;
      chk("lu_no_rdwren", V_DEF, V_DEF);
      tick();

      // rs2 dependency, then freeze while lat3 counter is 1
      load_dep(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
      chk("lu_rs2", V_LU, V_LU);
      tick();
      idle();
      chk("lu_rs2_w2", V_DEF, V_LU);
      tick();
      dmem_ready = 1'b0;
      chk("freeze1", V_FRZ, V_FRZ);
      tick();
      chk("freeze2", V_FRZ, V_FRZ);
      tick();
      dmem_ready = 1'b1;
      chk("freeze_release", V_DEF, V_LU);
      tick();
      chk("freeze_run", V_DEF, V_DEF);
      tick();

      // MDU op, done 4 cycles after entry
      mdu_done = 1'b1;
      chk("done_in_run", V_DEF, V_DEF);
      mdu_done = 1'b0;
      mdu = 1'b1;
      chk("mdu_start", V_MSTRT, V_MSTRT);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("mdu_hold%0d", i), V_MHOLD, V_MHOLD);
         tick();
      end
      mdu_done = 1'b1;
      chk("mdu_done", V_DEF, V_DEF);
      tick();
      idle();
      chk("mdu_run", V_DEF, V_DEF);
      tick();

      // Flush during MDU_WAIT kills the op
      mdu = 1'b1;
      chk("mdu_start2", V_MSTRT, V_MSTRT);
      tick();
      chk("mdu_hold2", V_MHOLD, V_MHOLD);
      br_flush = 1'b1;
      chk("flush_kill", V_FLK, V_FLK);
      tick();
      idle();
      chk("flush_kill_run", V_DEF, V_DEF);
      tick();

      // Flush beats a simultaneous load-use
      load_dep(5'd5, 5'd5, 1'b1, 5'd1, 1'b0);
      br_flush = 1'b1;
      chk("flush_over_lu", V_FL, V_FL);
      tick();
      idle();
      chk("flush_lu_run", V_DEF, V_DEF);
      tick();

      // Freeze beats a flush; flush served after release
      br_flush = 1'b1; dmem_ready = 1'b0;
      chk("freeze_over_flush", V_FRZ, V_FRZ);
      tick();
      dmem_ready = 1'b1;
      chk("flush_after_freeze", V_FL, V_FL);
      tick();
      idle();

      // Reset mid-MDU_WAIT: no kill, back to RUN
      mdu = 1'b1;
      chk("mdu_start3", V_MSTRT, V_MSTRT);
      tick();
      rst_ni = 1'b0;
      chk("reset_in_mdu", V_RST, V_RST);
      tick();
      rst_ni = 1'b1;
      idle();
      chk("after_reset_mdu", V_DEF, V_DEF);
      tick();

      // Reset mid-LOAD_WAIT on the multi-bubble instance
      load_dep(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
      chk("lu_hit3", V_LU, V_LU);
      tick();
      idle();
      rst_ni = 1'b0;
      chk("reset_in_load", V_RST, V_RST);
      tick();
      rst_ni = 1'b1;
      chk("after_reset_load", V_DEF, V_DEF);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
